// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD stream writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int DEF_SETUP_CYC     = 4;
  localparam int DEF_PULSE_CYC     = 12;
  localparam int DEF_HOLD_CYC      = 2;
  localparam int DEF_EXEC_CYC      = 2000;
  localparam int DEF_LONG_EXEC_CYC = 82000;
  localparam int DEF_POWERUP_CYC   = 2000000;
  localparam int DEF_CNT_W         = 21;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int RS_BIT = 8;
  localparam int WORD_W = 9;

  // Clear and return-home (bit 0 of home is don't-care) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with zero flag, shared by every timed state of the writer.
module lcd_timer #(
  parameter int               CNT_W   = 21,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_stream_writer.sv
// Consumes 9-bit {RS, byte} words and drives an 8-bit HD44780 write cycle with
// setup/pulse/hold timing followed by the controller's execution wait.
module lcd_stream_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int PULSE_CYC     = DEF_PULSE_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int EXEC_CYC      = DEF_EXEC_CYC,
  parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC,
  parameter int POWERUP_CYC   = DEF_POWERUP_CYC,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                clock_i,
  input  logic                rstn_i,
  input  logic [WORD_W-1:0]   data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                lcd_rs_o,
  output logic                lcd_rw_o,
  output logic                lcd_e_o,
  output logic [7:0]          lcd_db_o
);

  lcd_state_e       state_q, state_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             e_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             accept;

  assign ready_o = (state_q == ST_IDLE);
  assign accept  = valid_i & ready_o;

  lcd_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(POWERUP_CYC - 1))
  ) u_timer (
    .clock_i    (clock_i),
    .rstn_i     (rstn_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Each timed state reloads the shared timer with N-1 on entry and leaves on zero.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    rs_d     = rs_q;
    db_d     = db_q;
    case (state_q)
      ST_POWERUP: if (tmr_zero) state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SETUP_CYC - 1);
          rs_d     = data_i[RS_BIT];
          db_d     = data_i[7:0];
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PULSE_CYC - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d  = ST_EXEC;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, db_q) ? CNT_W'(LONG_EXEC_CYC - 1)
                                             : CNT_W'(EXEC_CYC - 1);
        end
      end
      ST_EXEC: if (tmr_zero) state_d = ST_IDLE;
      default: state_d = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_POWERUP;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      e_q     <= (state_d == ST_PULSE);
    end
  end

  assign lcd_rs_o = rs_q;
  assign lcd_db_o = db_q;
  assign lcd_e_o  = e_q;
  assign lcd_rw_o = 1'b0;

endmodule
